cpi_pixel_capture: RTL and testbench

Capture front-end fed by the camera pad bundle (pclk, hsync, vsync, data[9:0]). Runs on the pixel clock and tracks frame/line timing with row/column counters. Applies a crop window, packs pixels into 16-bit words and buffers them in a 4-entry FIFO. The FIFO drains over a valid/ready handshake toward the uDMA clock-domain-crossing stage.

---
 rtl/cpi_pixel_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_cpi_pixel_capture.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpi_pixel_capture.sv
// cpi_pixel_capture: camera parallel interface capture front-end.
// Tracks frame/line timing on the pixel clock, applies an optional crop
// window, packs pixels into 16-bit words and buffers them in a small
// first-word-fall-through FIFO drained over valid/ready.
// Optional feature macro: CPI_FRAME_SKIP_EN adds cfg_skip_i, which skips
// that many frames after each captured one.
module cpi_pixel_capture #(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cfg_en_i,
    input  logic [1:0]       cfg_format_i,
    input  logic             cfg_vsync_pol_i,
    input  logic             cfg_crop_en_i,
    input  logic [CNT_W-1:0] cfg_start_x_i,
    input  logic [CNT_W-1:0] cfg_start_y_i,
    input  logic [CNT_W-1:0] cfg_size_x_i,
    input  logic [CNT_W-1:0] cfg_size_y_i,
`ifdef CPI_FRAME_SKIP_EN
    input  logic [3:0]       cfg_skip_i,
`endif
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [9:0]       data_i,
    output logic [15:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_done_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SOF, ST_CAPTURE} state_e;

    state_e           state_q, state_d;
    logic             vs_q, hsync_q;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic             phase_q, phase_d;
    logic [7:0]       msb_q, msb_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [15:0]      mem_d [FIFO_DEPTH];
`ifdef CPI_FRAME_SKIP_EN
    logic [3:0]       skip_cnt_q, skip_cnt_d;
`endif

    // Internal active-high frame sync and edge strobes.
    logic vs, vs_rise, vs_fall, hs_rise, hs_fall;
    assign vs      = vsync_i ^ ~cfg_vsync_pol_i;
    assign vs_rise = vs & ~vs_q;
    assign vs_fall = ~vs & vs_q;
    assign hs_rise = hsync_i & ~hsync_q;
    assign hs_fall = ~hsync_i & hsync_q;

    // Crop window test, one bit wider so start+size cannot wrap.
    logic [CNT_W:0] pcol, x_hi, y_hi;
    logic           in_win, accept, capturing;
    assign pcol      = (cfg_format_i == 2'd0) ? {2'b0, col_q[CNT_W-1:1]} : {1'b0, col_q};
    assign x_hi      = {1'b0, cfg_start_x_i} + {1'b0, cfg_size_x_i};
    assign y_hi      = {1'b0, cfg_start_y_i} + {1'b0, cfg_size_y_i};
    assign in_win    = (pcol >= {1'b0, cfg_start_x_i}) && (pcol <= x_hi) &&
                       ({1'b0, row_q} >= {1'b0, cfg_start_y_i}) && ({1'b0, row_q} <= y_hi);
    assign capturing = (state_q == ST_CAPTURE);
    assign accept    = capturing && hsync_i && (!cfg_crop_en_i || in_win);

    // FIFO status and handshake.
    logic [PTR_W:0] fifo_cnt;
    logic           fifo_full, pop, push, wr_en, drop, start;
    logic [15:0]    push_data;
    assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign valid_o   = (fifo_cnt != '0);
    assign data_o    = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign pop       = valid_o && ready_i;
    assign wr_en     = push && (!fifo_full || pop);
    assign drop      = push && fifo_full && !pop;

    // Frame-level sequencing: start of frame, end of frame, enable handling.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no latch is inferred.
        state_d      = state_q;
        frame_done_d = 1'b0;
        start        = 1'b0;
`ifdef CPI_FRAME_SKIP_EN
        skip_cnt_d   = skip_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef CPI_FRAME_SKIP_EN
                skip_cnt_d = '0;
`endif
                if (cfg_en_i) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (!cfg_en_i) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
`ifdef CPI_FRAME_SKIP_EN
                    if (skip_cnt_q != '0) begin
                        skip_cnt_d = skip_cnt_q - 4'd1;
                    end else begin
                        start   = 1'b1;
                        state_d = ST_CAPTURE;
                    end
`else
                    start   = 1'b1;
                    state_d = ST_CAPTURE;
`endif
                end
            end
            ST_CAPTURE: begin
                if (vs_fall) begin
                    frame_done_d = 1'b1;
                    state_d      = cfg_en_i ? ST_WAIT_SOF : ST_IDLE;
`ifdef CPI_FRAME_SKIP_EN
                    skip_cnt_d   = cfg_skip_i;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CAPTURE);
    end

    // Row/column counters and pixel packing.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        phase_d   = hs_rise ? 1'b0 : phase_q;
        msb_d     = msb_q;
        push      = 1'b0;
        push_data = '0;
        if (capturing) begin
            if (!hsync_i)          col_d = '0;
            else if (~&col_q)      col_d = col_q + 1'b1;
            if (hs_fall && ~&row_q) row_d = row_q + 1'b1;
        end
        if (accept) begin
            case (cfg_format_i)
                2'd0: begin
                    if (!phase_d) begin
                        msb_d   = data_i[7:0];
                        phase_d = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = {msb_q, data_i[7:0]};
                        phase_d   = 1'b0;
                    end
                end
                2'd1:    begin push = 1'b1; push_data = {6'b0, data_i}; end
                default: begin push = 1'b1; push_data = {8'b0, data_i[7:0]}; end
            endcase
        end
        if (start) begin
            col_d   = '0;
            row_d   = '0;
            phase_d = 1'b0;
        end
    end

    // FIFO pointers, storage and sticky overflow; flushed whenever heading to IDLE.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
        if (state_d == ST_IDLE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, wr_en};
            rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        end
        overflow_d = (state_q == ST_IDLE) ? 1'b0 : (overflow_q | drop);
    end

    // State register for the whole block.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            vs_q         <= 1'b0;
            hsync_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            phase_q      <= 1'b0;
            msb_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            // NOTE: the FIFO storage is reset because data_o shows the head entry and must read 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef CPI_FRAME_SKIP_EN
            skip_cnt_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            vs_q         <= vs;
            hsync_q      <= hsync_i;
            col_q        <= col_d;
            row_q        <= row_d;
            phase_q      <= phase_d;
            msb_q        <= msb_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
`ifdef CPI_FRAME_SKIP_EN
            skip_cnt_q   <= skip_cnt_d;
`endif
        end
    end

    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_cpi_pixel_capture.sv
// Self-checking bench for cpi_pixel_capture: random pixel data, a
// line/frame level reference model, and a consumer monitor.
module tb_cpi_pixel_capture;
    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic             cfg_en_i;
    logic [1:0]       cfg_format_i;
    logic             cfg_vsync_pol_i;
    logic             cfg_crop_en_i;
    logic [CNT_W-1:0] cfg_start_x_i, cfg_start_y_i, cfg_size_x_i, cfg_size_y_i;
    logic [3:0]       cfg_skip_i;
    logic             hsync_i, vsync_i;
    logic [9:0]       data_i;
    logic [15:0]      data_o;
    logic             valid_o, ready_i, frame_done_o, overflow_o, busy_o;

    cpi_pixel_capture #(.CNT_W(CNT_W), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_format_i(cfg_format_i),
        .cfg_vsync_pol_i(cfg_vsync_pol_i), .cfg_crop_en_i(cfg_crop_en_i),
        .cfg_start_x_i(cfg_start_x_i), .cfg_start_y_i(cfg_start_y_i),
        .cfg_size_x_i(cfg_size_x_i), .cfg_size_y_i(cfg_size_y_i),
`ifdef CPI_FRAME_SKIP_EN
        .cfg_skip_i(cfg_skip_i),
`endif
        .hsync_i(hsync_i), .vsync_i(vsync_i), .data_i(data_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .frame_done_o(frame_done_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] ref_q[$];
    logic [9:0]  pix [8][16];

    // Consumer monitor: a word is taken at the edge following a negedge with valid && ready.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (frame_done_o) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fill_pix();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                pix[r][c] = 10'($urandom);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    // Drive one frame and extend the expected-word queue from the window/packing rules.
    task automatic send_frame(input int fmt, input int lines, input int samples,
                              input bit capture, input int drop_line);
        logic [7:0] acc[$];
        int  pcol;
        bit  in_win;
        vsync_i = !cfg_vsync_pol_i;
        tick(); tick();
        vsync_i = cfg_vsync_pol_i;
        tick(); tick(); tick();
        for (int r = 0; r < lines; r++) begin
            acc.delete();
            for (int c = 0; c < samples; c++) begin
                hsync_i = 1'b1;
                data_i  = pix[r][c];
                pcol    = (fmt == 0) ? c / 2 : c;
                in_win  = !cfg_crop_en_i ||
                          (pcol >= int'(cfg_start_x_i) && pcol <= int'(cfg_start_x_i) + int'(cfg_size_x_i) &&
                           r >= int'(cfg_start_y_i) && r <= int'(cfg_start_y_i) + int'(cfg_size_y_i));
                if (capture && in_win) begin
                    if (fmt == 0)      acc.push_back(pix[r][c][7:0]);
                    else if (fmt == 1) exp_q.push_back({6'b0, pix[r][c]});
                    else               exp_q.push_back({8'b0, pix[r][c][7:0]});
                end
                if (r == 0 && c == 0) begin
                    n_vec++;
                    if (busy_o !== capture) begin
                        n_err++;
                        $display("FAIL busy_in_frame got %b exp %b", busy_o, capture);
                    end
                end
                tick();
            end
            for (int k = 0; k + 1 < acc.size(); k += 2) exp_q.push_back({acc[k], acc[k+1]});
            hsync_i = 1'b0;
            data_i  = '0;
            if (r == drop_line) cfg_en_i = 1'b0;
            tick(); tick(); tick();
        end
        vsync_i = !cfg_vsync_pol_i;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        tick(); tick();
        n_vec++; if (data_o !== 16'h0)     begin n_err++; $display("FAIL reset_data got %h exp 0000", data_o); end
        n_vec++; if (valid_o !== 1'b0)     begin n_err++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        n_vec++; if (frame_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", frame_done_o); end
        n_vec++; if (overflow_o !== 1'b0)  begin n_err++; $display("FAIL reset_ovf got %b exp 0", overflow_o); end
        n_vec++; if (busy_o !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_rgb565();
        cfg_format_i = 2'd0; cfg_crop_en_i = 1'b0; cfg_en_i = 1'b1;
        fill_pix();
        tick(); tick();
        clear_obs();
        send_frame(0, 2, 8, 1'b1, -1);
        n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL rgb565_count got %0d exp 8", got_q.size()); end
        n_vec++;
        if (got_q.size() == 0 || got_q[0] !== {pix[0][0][7:0], pix[0][1][7:0]}) begin
            n_err++; $display("FAIL rgb565_first got %h exp %h", (got_q.size() > 0) ? got_q[0] : 16'hxxxx,
                              {pix[0][0][7:0], pix[0][1][7:0]});
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rgb565_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL rgb565_done got %0d exp 1", done_cnt); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rgb565_busy_after got %b exp 0", busy_o); end
    endtask

    task automatic test_raw10_crop();
        cfg_format_i = 2'd1; cfg_crop_en_i = 1'b1;
        cfg_start_x_i = 16'd1; cfg_start_y_i = 16'd1; cfg_size_x_i = 16'd1; cfg_size_y_i = 16'd0;
        fill_pix();
        clear_obs();
        send_frame(1, 3, 4, 1'b1, -1);
        n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL crop_count got %0d exp 2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL crop_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        cfg_crop_en_i = 1'b0;
    endtask

    task automatic test_overflow();
        cfg_format_i = 2'd2; ready_i = 1'b0;
        fill_pix();
        clear_obs();
        send_frame(2, 1, 8, 1'b1, -1);
        n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", overflow_o); end
        n_vec++; if (valid_o !== 1'b1)    begin n_err++; $display("FAIL ovf_valid got %b exp 1", valid_o); end
        n_vec++; if (got_q.size() != 0)   begin n_err++; $display("FAIL ovf_held got %0d exp 0", got_q.size()); end
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_vec++; if (got_q.size() != 4)   begin n_err++; $display("FAIL ovf_drain_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", overflow_o); end
        cfg_en_i = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow_o); end
        n_vec++; if (done_cnt != 1)       begin n_err++; $display("FAIL ovf_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_en_drop();
        cfg_format_i = 2'd2; cfg_en_i = 1'b1;
        fill_pix();
        tick(); tick();
        clear_obs();
        send_frame(2, 3, 6, 1'b1, 1);
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL endrop_done got %0d exp 1", done_cnt); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL endrop_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL endrop_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        clear_obs();
        send_frame(2, 2, 4, 1'b0, -1);
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL endrop_ignored got %0d exp 0", got_q.size()); end
        n_vec++; if (done_cnt != 0)     begin n_err++; $display("FAIL endrop_ignored_done got %0d exp 0", done_cnt); end
    endtask

    task automatic test_vsync_pol();
        cfg_format_i = 2'd0; cfg_en_i = 1'b1; cfg_vsync_pol_i = 1'b1; vsync_i = 1'b0;
        fill_pix();
        tick(); tick();
        clear_obs();
        send_frame(0, 2, 6, 1'b1, -1);
        ref_q = got_q;
        cfg_vsync_pol_i = 1'b0; vsync_i = 1'b1;
        tick(); tick();
        clear_obs();
        send_frame(0, 2, 6, 1'b1, -1);
        n_vec++; if (got_q.size() != ref_q.size() || got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL pol_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== ref_q[i] || got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL pol_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL pol_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_random();
        int fmt, lines, samples;
        for (int f = 0; f < 6; f++) begin
            fmt = $urandom_range(0, 3);
            cfg_format_i    = 2'(fmt);
            cfg_vsync_pol_i = 1'($urandom);
            vsync_i         = !cfg_vsync_pol_i;
            cfg_crop_en_i   = 1'($urandom);
            cfg_start_x_i   = 16'($urandom_range(0, 2));
            cfg_size_x_i    = 16'($urandom_range(0, 3));
            cfg_start_y_i   = 16'($urandom_range(0, 2));
            cfg_size_y_i    = 16'($urandom_range(0, 2));
            lines   = $urandom_range(2, 4);
            samples = $urandom_range(2, 9);
            fill_pix();
            tick(); tick();
            clear_obs();
            send_frame(fmt, lines, samples, 1'b1, -1);
            n_vec++; if (got_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL rand%0d_count got %0d exp %0d", f, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_word%0d got %h exp %h", f, i, got_q[i], exp_q[i]); end
            end
            n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL rand%0d_done got %0d exp 1", f, done_cnt); end
        end
        cfg_crop_en_i = 1'b0;
    endtask

    task automatic test_reset_mid_line();
        cfg_format_i = 2'd1; cfg_vsync_pol_i = 1'b1; vsync_i = 1'b0; cfg_en_i = 1'b1; ready_i = 1'b0;
        fill_pix();
        tick(); tick();
        vsync_i = 1'b1;
        tick(); tick(); tick();
        hsync_i = 1'b1; data_i = pix[0][0];
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL lat_empty got %b exp 0", valid_o); end
        tick();
        data_i = pix[0][1];
        n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL lat_valid got %b exp 1", valid_o); end
        n_vec++; if (data_o !== {6'b0, pix[0][0]}) begin n_err++; $display("FAIL lat_data got %h exp %h", data_o, {6'b0, pix[0][0]}); end
        tick();
        #3;
        rstn_i = 1'b0;
        #1;
        n_vec++; if (data_o !== 16'h0)      begin n_err++; $display("FAIL rstmid_data got %h exp 0000", data_o); end
        n_vec++; if (valid_o !== 1'b0)      begin n_err++; $display("FAIL rstmid_valid got %b exp 0", valid_o); end
        n_vec++; if (busy_o !== 1'b0)       begin n_err++; $display("FAIL rstmid_busy got %b exp 0", busy_o); end
        n_vec++; if (overflow_o !== 1'b0)   begin n_err++; $display("FAIL rstmid_ovf got %b exp 0", overflow_o); end
        n_vec++; if (frame_done_o !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b exp 0", frame_done_o); end
        hsync_i = 1'b0; vsync_i = 1'b0; data_i = '0; ready_i = 1'b1;
        tick(); tick();
        rstn_i = 1'b1;
        tick();
        clear_obs();
    endtask

`ifdef CPI_FRAME_SKIP_EN
    task automatic test_frame_skip();
        cfg_format_i = 2'd2; cfg_vsync_pol_i = 1'b1; vsync_i = 1'b0; cfg_en_i = 1'b1; cfg_skip_i = 4'd2;
        tick(); tick();
        clear_obs();
        for (int f = 0; f < 6; f++) begin
            fill_pix();
            send_frame(2, 1, 4, (f % 3) == 0, -1);
        end
        n_vec++; if (done_cnt != 2) begin n_err++; $display("FAIL skip_done got %0d exp 2", done_cnt); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL skip_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL skip_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_format_i = 2'd0; cfg_vsync_pol_i = 1'b1;
        cfg_crop_en_i = 1'b0; cfg_start_x_i = '0; cfg_start_y_i = '0; cfg_size_x_i = '0; cfg_size_y_i = '0;
        cfg_skip_i = '0; hsync_i = 1'b0; vsync_i = 1'b0; data_i = '0; ready_i = 1'b1;
        test_reset();
        test_rgb565();
        test_raw10_crop();
        test_overflow();
        test_en_drop();
        test_vsync_pol();
        test_random();
        test_reset_mid_line();
`ifdef CPI_FRAME_SKIP_EN
        test_frame_skip();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
